// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the quadrature receive path: code order,
// direction encoding and the Gray-to-phase helper used by the decoder.
package gray_pkg;

  localparam logic [1:0] GRAY_SEQ [0:3] = '{2'b00, 2'b01, 2'b11, 2'b10};

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_ERR  = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

  function automatic logic [1:0] gray2_to_phase(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Phase difference mod 4 maps directly onto the step encoding.
  function automatic step_e classify(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray2_to_phase(cur) - gray2_to_phase(prev);
    return step_e'(d);
  endfunction

endpackage

// File: rtl/gray_sync_filter.sv
// Two-flop synchronizer for the raw Gray pins, with an optional stability
// filter enabled by the GRAY_DEBOUNCE_EN macro; produces the accepted code.
module gray_sync_filter
`ifdef GRAY_DEBOUNCE_EN
  #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5
  )
`endif
  (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gray_in,
    output logic [1:0] acc,
    output logic       acc_vld
  );

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic       vld_p0;
  logic       vld_p1;

  // Stage p0/p1: metastability flops; vld marks when real pin samples arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= gray_in;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

`ifdef GRAY_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 2);

  logic [1:0]       held_p2;
  logic [DEB_W-1:0] cnt_p2;

  // Stage p2: a code is accepted once it has stayed put for DEB_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_p2 <= 2'b00;
      cnt_p2  <= '0;
      acc     <= 2'b00;
      acc_vld <= 1'b0;
    end else if (!vld_p1) begin
      cnt_p2 <= '0;
    end else if (sync_p1 != held_p2) begin
      held_p2 <= sync_p1;
      cnt_p2  <= '0;
    end else if (cnt_p2 == DEB_LAST) begin
      acc     <= held_p2;
      acc_vld <= 1'b1;
    end else begin
      cnt_p2 <= cnt_p2 + 1'b1;
    end
  end
`else
  assign acc     = sync_p1;
  assign acc_vld = vld_p1;
`endif

endmodule

// File: rtl/gray_quad_decoder.sv
// Quadrature Gray decoder: synchronized code -> up/down position counter with
// step/dir/err flags. Optional input debounce via the GRAY_DEBOUNCE_EN macro.
module gray_quad_decoder
  import gray_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       gray_in,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             err_sticky
);

  logic [1:0] acc;
  logic       acc_vld;
  logic [1:0] prev_code;
  logic       primed;
  step_e      kind;

  // Debounce filter needs DEB_CYCLES >= 2 and a counter wide enough to reach it.
  if (DEB_CYCLES < 2 || DEB_CYCLES >= (1 << DEB_W)) begin : g_illegal_deb_cfg
  end

`ifdef GRAY_DEBOUNCE_EN
  gray_sync_filter #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_filter (
`else
  gray_sync_filter u_filter (
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_in (gray_in),
    .acc     (acc),
    .acc_vld (acc_vld)
  );

  assign kind = classify(prev_code, acc);

  // Decode stage: prev_code always tracks acc so clr or err never leave a phantom step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code  <= 2'b00;
      primed     <= 1'b0;
      count      <= '0;
      step       <= 1'b0;
      dir        <= DIR_DOWN;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      if (!primed) begin
        if (acc_vld) begin
          prev_code <= acc;
          primed    <= 1'b1;
        end
        if (clr) begin
          count      <= '0;
          err_sticky <= 1'b0;
        end
      end else begin
        prev_code <= acc;
        if (clr) begin
          count      <= '0;
          err_sticky <= 1'b0;
        end else begin
          case (kind)
            STEP_UP: begin
              count <= count + CNT_W'(1);
              dir   <= DIR_UP;
              step  <= 1'b1;
            end
            STEP_DOWN: begin
              count <= count - CNT_W'(1);
              dir   <= DIR_DOWN;
              step  <= 1'b1;
            end
            STEP_ERR: begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_quad_decoder.sv
// Scoreboard bench for gray_quad_decoder: a reference model pushes expected
// pulses when codes are driven; a monitor pops and checks them on DUT output.
module tb_gray_quad_decoder;

  localparam int CNT_W = 4;
`ifdef GRAY_DEBOUNCE_EN
  localparam int LAT = 3 + 16;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic [1:0]       gray_in = 2'b00;
  logic [CNT_W-1:0] count;
  logic             step, dir, err, err_sticky;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int               at;
    logic             is_err;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             sticky;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [1:0]       m_prev = 2'b00;
  logic [CNT_W-1:0] m_count = '0;
  logic             m_dir = 1'b0;
  logic             m_sticky = 1'b0;

  gray_quad_decoder #(.CNT_W(CNT_W), .DEB_CYCLES(16), .DEB_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .clr        (clr),
    .count      (count),
    .step       (step),
    .dir        (dir),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Position of a code within the up sequence 00,01,11,10.
  function automatic int pos(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic drive(input logic [1:0] g, input int hold);
    int   d;
    exp_t e;
    d = (pos(g) - pos(m_prev)) & 3;
    if (d == 1) begin
      m_count++;
      m_dir = 1'b1;
    end else if (d == 3) begin
      m_count--;
      m_dir = 1'b0;
    end else if (d == 2) begin
      m_sticky = 1'b1;
    end
    if (d != 0) begin
      e.at     = cyc + LAT;
      e.is_err = (d == 2);
      e.cnt    = m_count;
      e.dir    = m_dir;
      e.sticky = m_sticky;
      sb.push_back(e);
    end
    gray_in = g;
    m_prev  = g;
    repeat (hold) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    chk({tag, "_count"}, count, m_count);
    chk({tag, "_dir"}, dir, m_dir);
    chk({tag, "_sticky"}, err_sticky, m_sticky);
    chk({tag, "_drained"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (step || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {step, err}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_cycle", cyc, mon_e.at);
        chk("pulse_kind", {step, err}, {~mon_e.is_err, mon_e.is_err});
        chk("pulse_count", count, mon_e.cnt);
        chk("pulse_dir", dir, mon_e.dir);
        chk("pulse_sticky", err_sticky, mon_e.sticky);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", err_sticky, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    drive(2'b00, 40);
    drive(2'b01, 40);
    drive(2'b11, 40);
    drive(2'b10, 40);
    drive(2'b00, 40);
    chk("up_count4", count, 4);
    settle("up");

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_count = '0;
    m_sticky = 1'b0;
    @(negedge clk);
    settle("clr");

    drive(2'b00, 40);
    drive(2'b10, 40);
    chk("wrap_count15", count, 15);
    drive(2'b11, 40);
    chk("wrap_count14", count, 14);
    settle("down");

    drive(2'b10, 40);
    drive(2'b00, 40);
    drive(2'b11, 40);
    chk("err_sticky_set", err_sticky, 1);
    settle("err");
    drive(2'b10, 40);
    settle("resync");

    drive(2'b00, 40);
    drive(2'b01, 40);
    drive(2'b11, 40);
    drive(2'b10, 40);
    chk("pre_clr_count5", count, 5);

    gray_in = 2'b00;
    m_prev = 2'b00;
    m_count = '0;
    m_sticky = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrstep_count", count, 0);
    chk("clrstep_step", step, 0);
    chk("clrstep_sticky", err_sticky, 0);
    repeat (40) @(negedge clk);
    settle("clrstep");
    drive(2'b01, 40);
    settle("no_phantom");

    drive(2'b00, 40);
`ifdef GRAY_DEBOUNCE_EN
    gray_in = 2'b01;
    repeat (5) @(negedge clk);
    gray_in = 2'b00;
    repeat (40) @(negedge clk);
    settle("glitch");
    drive(2'b01, 20);
    repeat (20) @(negedge clk);
    drive(2'b00, 40);
`else
    drive(2'b01, 5);
    drive(2'b00, 40);
`endif
    settle("glitch");

    drive(2'b01, 40);
    gray_in = 2'b11;
    m_prev = 2'b11;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_step", step, 0);
    chk("midrst_dir", dir, 0);
    chk("midrst_err", err, 0);
    chk("midrst_sticky", err_sticky, 0);
    sb.delete();
    m_count = '0;
    m_dir = 1'b0;
    m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    settle("reprime");
    drive(2'b10, 40);
    chk("post_rst_count1", count, 1);
    settle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
